// File: rtl/fpu_fcom_seq.sv
// Compare sequencer for FCOM/FUCOM/FCOMI-class ops around a shared fp64 comparator.
// NaN/Inf operands resolve locally. Finite operands go through the comparator.
module fpu_fcom_seq #(
  parameter int CMP_LAT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [63:0] req_a,
  input  logic [63:0] req_b,
  input  logic [2:0]  req_op,
  input  logic        ie_mask,
  output logic [63:0] cmp_a,
  output logic [63:0] cmp_b,
  input  logic        cmp_lt,
  input  logic        cmp_eq,
  input  logic        cmp_gt,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_wr_cc,
  output logic        rsp_c3,
  output logic        rsp_c2,
  output logic        rsp_c0,
  output logic        rsp_zf,
  output logic        rsp_pf,
  output logic        rsp_cf,
  output logic [1:0]  rsp_pop,
  output logic        rsp_ie,
  output logic        rsp_de
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_e;

  localparam logic [1:0] WAIT_INIT = (CMP_LAT > 0) ? 2'(CMP_LAT - 1) : 2'd0;

  function automatic logic f_nan(input logic [63:0] x);
    return (x[62:52] == 11'h7FF) && (x[51:0] != '0);
  endfunction

  function automatic logic f_inf(input logic [63:0] x);
    return (x[62:52] == 11'h7FF) && (x[51:0] == '0);
  endfunction

  function automatic logic f_den(input logic [63:0] x);
    return (x[62:52] == 11'h000) && (x[51:0] != '0);
  endfunction

  function automatic logic [1:0] f_pop(input logic [2:0] op);
    case (op)
      3'd1, 3'd4: return 2'd1;
      3'd2, 3'd5: return 2'd2;
      default:    return 2'd0;
    endcase
  endfunction

  state_e      state_q, state_d;
  logic [1:0]  cnt_q;
  logic [63:0] a_q, b_q;
  logic [2:0]  op_q;
  logic        den_q;
  logic [2:0]  cc_q;
  logic        wr_cc_q, ie_q, de_q;
  logic [1:0]  pop_q;

  logic       accept, sample, fast;
  logic       a_nan, b_nan, any_snan, any_nan, ordered_op, ie_acc, den_acc;
  logic [2:0] fast_cc, sample_cc;
  logic [1:0] pop_acc;

  assign accept = req_valid && (state_q == S_IDLE);
  assign sample = ((state_q == S_ISSUE) && (CMP_LAT == 0)) ||
                  ((state_q == S_WAIT) && (cnt_q == 2'd0));

  // Classification of the incoming pair, only meaningful in the accept cycle.
  assign a_nan      = f_nan(req_a);
  assign b_nan      = f_nan(req_b);
  assign any_nan    = a_nan || b_nan;
  assign any_snan   = (a_nan && !req_a[51]) || (b_nan && !req_b[51]);
  assign ordered_op = (req_op == 3'd0) || (req_op == 3'd1) || (req_op == 3'd2) || (req_op == 3'd6);
  assign ie_acc     = any_snan || (any_nan && ordered_op);
  assign pop_acc    = (ie_acc && !ie_mask) ? 2'd0 : f_pop(req_op);
  assign den_acc    = f_den(req_a) || f_den(req_b);
  assign fast       = any_nan || f_inf(req_a) || f_inf(req_b);

  // NOTE: every variable assigned in a combinational block gets a default first,
  // so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    fast_cc = 3'b000;
    if (any_nan)                                           fast_cc = 3'b111;
    else if (f_inf(req_a) && f_inf(req_b) && (req_a[63] == req_b[63])) fast_cc = 3'b100;
    else if (f_inf(req_a))                                 fast_cc = req_a[63] ? 3'b001 : 3'b000;
    else                                                   fast_cc = req_b[63] ? 3'b000 : 3'b001;
  end

  // Comparator priority eq > lt > gt; nothing asserted reads as gt.
  assign sample_cc = cmp_eq ? 3'b100 : (cmp_lt ? 3'b001 : 3'b000);

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // sees the pre-edge values of the others regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = fast ? S_RESP : S_ISSUE;
      S_ISSUE: state_d = (CMP_LAT == 0) ? S_RESP : S_WAIT;
      S_WAIT:  if (cnt_q == 2'd0) state_d = S_RESP;
      S_RESP:  if (rsp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q   <= 2'd0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= 3'd0;
      den_q   <= 1'b0;
      cc_q    <= 3'b000;
      wr_cc_q <= 1'b0;
      pop_q   <= 2'd0;
      ie_q    <= 1'b0;
      de_q    <= 1'b0;
    end else begin
      if (accept) begin
        a_q   <= req_a;
        b_q   <= req_b;
        op_q  <= req_op;
        den_q <= den_acc;
        if (fast) begin
          cc_q    <= fast_cc;
          wr_cc_q <= (req_op < 3'd6);
          pop_q   <= pop_acc;
          ie_q    <= ie_acc;
          de_q    <= den_acc;
        end
      end
      if (state_q == S_ISSUE)                         cnt_q <= WAIT_INIT;
      else if (state_q == S_WAIT && cnt_q != 2'd0)    cnt_q <= cnt_q - 2'd1;
      // Finite operands can never raise invalid, so the mask plays no part here.
      if (sample) begin
        cc_q    <= sample_cc;
        wr_cc_q <= (op_q < 3'd6);
        pop_q   <= f_pop(op_q);
        ie_q    <= 1'b0;
        de_q    <= den_q;
      end
    end
  end

  always_comb begin
    req_ready = (state_q == S_IDLE) && rst_n;
    rsp_valid = (state_q == S_RESP);
    cmp_a     = '0;
    cmp_b     = '0;
    if (state_q == S_ISSUE || state_q == S_WAIT) begin
      cmp_a = a_q;
      cmp_b = b_q;
    end
    rsp_wr_cc = wr_cc_q;
    rsp_c3    = cc_q[2];
    rsp_c2    = cc_q[1];
    rsp_c0    = cc_q[0];
    rsp_zf    = cc_q[2];
    rsp_pf    = cc_q[1];
    rsp_cf    = cc_q[0];
    rsp_pop   = pop_q;
    rsp_ie    = ie_q;
    rsp_de    = de_q;
  end

endmodule

// File: tb/tb_fpu_fcom_seq.sv
// Scoreboard bench for fpu_fcom_seq: directed requests push expected responses,
// a monitor pops and compares on each response handshake.
module tb_fpu_fcom_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready;
  logic [63:0] req_a, req_b;
  logic [2:0]  req_op;
  logic        ie_mask;
  logic [63:0] cmp_a, cmp_b;
  logic        cmp_lt, cmp_eq, cmp_gt;
  logic        rsp_valid, rsp_ready;
  logic        rsp_wr_cc, rsp_c3, rsp_c2, rsp_c0, rsp_zf, rsp_pf, rsp_cf;
  logic [1:0]  rsp_pop;
  logic        rsp_ie, rsp_de;

  fpu_fcom_seq #(.CMP_LAT(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op), .ie_mask(ie_mask),
    .cmp_a(cmp_a), .cmp_b(cmp_b),
    .cmp_lt(cmp_lt), .cmp_eq(cmp_eq), .cmp_gt(cmp_gt),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_wr_cc(rsp_wr_cc), .rsp_c3(rsp_c3), .rsp_c2(rsp_c2), .rsp_c0(rsp_c0),
    .rsp_zf(rsp_zf), .rsp_pf(rsp_pf), .rsp_cf(rsp_cf),
    .rsp_pop(rsp_pop), .rsp_ie(rsp_ie), .rsp_de(rsp_de)
  );

  always #5 clk = ~clk;

  localparam logic [2:0] M_LT = 3'b001, M_EQ = 3'b010, M_GT = 3'b100,
                         M_NONE = 3'b000, M_ALL = 3'b111;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Comparator model: answers only once the operands have been held for one cycle.
  logic [63:0] m_a, m_b, cmp_a_dly;
  logic [2:0]  m_sel;
  logic        m_ok;
  always @(posedge clk) cmp_a_dly <= cmp_a;
  assign m_ok   = (cmp_a == m_a) && (cmp_a_dly == m_a) && (cmp_b == m_b);
  assign cmp_lt = m_ok & m_sel[0];
  assign cmp_eq = m_ok & m_sel[1];
  assign cmp_gt = m_ok & m_sel[2];

  typedef struct {
    string      name;
    logic [10:0] flds;
    int         lat;
    int         acc;
  } exp_t;
  exp_t sbq[$];

  function automatic logic [10:0] pack(input logic [2:0] cc, input logic wr,
                                       input logic [1:0] pop, input logic ie, input logic de);
    return {cc, cc, wr, pop, ie, de};
  endfunction

  function automatic logic [10:0] actual();
    return {rsp_c3, rsp_c2, rsp_c0, rsp_zf, rsp_pf, rsp_cf, rsp_wr_cc, rsp_pop, rsp_ie, rsp_de};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: latency measured from accept to first rsp_valid, fields at handshake.
  bit seen = 0;
  int first_cyc = 0;
  always @(negedge clk) begin
    if (!rst_n) seen = 0;
    else if (rsp_valid) begin
      if (!seen) begin
        seen = 1;
        first_cyc = cyc;
      end
      if (rsp_ready) begin
        seen = 0;
        if (sbq.size() == 0) check("rsp with empty scoreboard", sbq.size(), 1);
        else begin
          exp_t e;
          e = sbq.pop_front();
          check({e.name, " fields"}, actual(), e.flds);
          check({e.name, " latency"}, first_cyc - e.acc + 1, e.lat);
        end
      end
    end
  end

  task automatic issue(input string name, input logic [63:0] a, input logic [63:0] b,
                       input logic [2:0] op, input logic mask, input logic [2:0] sel,
                       input logic [2:0] cc, input logic [1:0] pop, input logic ie,
                       input logic de, input int lat, input bit expect_rsp);
    @(negedge clk);
    for (int i = 0; i < 20 && !req_ready; i++) @(negedge clk);
    check({name, " req_ready"}, req_ready, 1);
    req_a = a; req_b = b; req_op = op; ie_mask = mask;
    m_a = a; m_b = b; m_sel = sel;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    if (expect_rsp)
      sbq.push_back('{name: name, flds: pack(cc, (op < 3'd6), pop, ie, de), lat: lat, acc: cyc});
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 50 && sbq.size() != 0; i++) @(negedge clk);
    check({name, " drained"}, sbq.size(), 0);
  endtask

  logic [10:0] snap;

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_a = '0; req_b = '0; req_op = '0;
    ie_mask = 1'b1; rsp_ready = 1'b1; m_a = '1; m_b = '1; m_sel = M_NONE;
    repeat (3) @(negedge clk);
    check("reset req_ready", req_ready, 0);
    check("reset rsp_valid", rsp_valid, 0);
    check("reset cmp_a", cmp_a, 0);
    check("reset rsp fields", actual(), 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post-reset req_ready", req_ready, 1);

    issue("fcom lt", 64'h3FF0000000000000, 64'h4000000000000000, 3'd0, 1'b1, M_LT,
          3'b001, 2'd0, 1'b0, 1'b0, 3, 1);
    @(negedge clk);
    check("fcom cmp_a in issue", cmp_a, 64'h3FF0000000000000);
    check("fcom cmp_b in issue", cmp_b, 64'h4000000000000000);
    drain("fcom lt");

    issue("fcompp qnan im1", 64'h7FF8000000000000, 64'h3FF0000000000000, 3'd2, 1'b1, M_LT,
          3'b111, 2'd2, 1'b1, 1'b0, 1, 1);
    @(negedge clk);
    check("fcompp cmp_a idle", cmp_a, 0);
    drain("fcompp qnan im1");
    issue("fcompp qnan im0", 64'h7FF8000000000000, 64'h3FF0000000000000, 3'd2, 1'b0, M_LT,
          3'b111, 2'd0, 1'b1, 1'b0, 1, 1);
    drain("fcompp qnan im0");

    issue("fucomi qnan", 64'h7FF8000000000000, 64'h0, 3'd7, 1'b1, M_EQ,
          3'b111, 2'd0, 1'b0, 1'b0, 1, 1);
    drain("fucomi qnan");
    issue("fucomi snan", 64'h7FF0000000000001, 64'h0, 3'd7, 1'b1, M_EQ,
          3'b111, 2'd0, 1'b1, 1'b0, 1, 1);
    drain("fucomi snan");

    issue("fcom +inf -inf", 64'h7FF0000000000000, 64'hFFF0000000000000, 3'd0, 1'b1, M_LT,
          3'b000, 2'd0, 1'b0, 1'b0, 1, 1);
    drain("fcom +inf -inf");
    issue("fcom +inf +inf", 64'h7FF0000000000000, 64'h7FF0000000000000, 3'd0, 1'b1, M_LT,
          3'b100, 2'd0, 1'b0, 1'b0, 1, 1);
    drain("fcom +inf +inf");
    issue("fcom 1 vs +inf", 64'h3FF0000000000000, 64'h7FF0000000000000, 3'd0, 1'b1, M_GT,
          3'b001, 2'd0, 1'b0, 1'b0, 1, 1);
    drain("fcom 1 vs +inf");
    issue("fcomi -inf vs 1", 64'hFFF0000000000000, 64'h3FF0000000000000, 3'd6, 1'b1, M_GT,
          3'b001, 2'd0, 1'b0, 1'b0, 1, 1);
    drain("fcomi -inf vs 1");

    issue("fucom denorm", 64'h0000000000000001, 64'h8000000000000000, 3'd3, 1'b1, M_EQ,
          3'b100, 2'd0, 1'b0, 1'b1, 3, 1);
    drain("fucom denorm");
    issue("fucomp none->gt", 64'h4000000000000000, 64'h3FF0000000000000, 3'd4, 1'b1, M_NONE,
          3'b000, 2'd1, 1'b0, 1'b0, 3, 1);
    drain("fucomp none->gt");
    issue("fucompp eq prio", 64'h3FF0000000000000, 64'h3FF0000000000000, 3'd5, 1'b1, M_ALL,
          3'b100, 2'd2, 1'b0, 1'b0, 3, 1);
    drain("fucompp eq prio");

    // Back-pressure: response must hold while rsp_ready is low.
    rsp_ready = 1'b0;
    issue("fcomp stall", 64'h3FF0000000000000, 64'h3FF0000000000000, 3'd1, 1'b1, M_EQ,
          3'b100, 2'd1, 1'b0, 1'b0, 3, 1);
    for (int i = 0; i < 20 && !rsp_valid; i++) @(negedge clk);
    snap = actual();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall fields stable", actual(), snap);
      check("stall rsp_valid", rsp_valid, 1);
      check("stall req_ready", req_ready, 0);
    end
    rsp_ready = 1'b1;
    drain("fcomp stall");

    // Reset while waiting on the comparator: no response may follow.
    issue("rst in wait", 64'h3FF0000000000000, 64'h4000000000000000, 3'd0, 1'b1, M_LT,
          3'b001, 2'd0, 1'b0, 1'b0, 3, 0);
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("rst wait rsp_valid", rsp_valid, 0);
    check("rst wait req_ready", req_ready, 0);
    check("rst wait cmp_a", cmp_a, 0);
    rst_n = 1'b1;
    issue("after reset", 64'h4000000000000000, 64'h3FF0000000000000, 3'd0, 1'b1, M_GT,
          3'b000, 2'd0, 1'b0, 1'b0, 3, 1);
    drain("after reset");
    repeat (5) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
